// File: rtl/simon_pkg.sv
// simon_pkg: shared colour/flash types and constants for the colour sequencer
package simon_pkg;
  typedef enum logic [1:0] {RED = 2'd0, GREEN = 2'd1, BLUE = 2'd2, YELLOW = 2'd3} colour_t;
  typedef enum logic [1:0] {IDLE, ON, GAP, DONE} flash_state_t;
  localparam int ROUND_MAX = 32;
  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
  function automatic logic [3:0] onehot(colour_t c);
    return 4'b0001 << c;
  endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11), seedable, steps on demand
module lfsr16
  import simon_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] q
);
  logic fb;
  assign fb = q[0] ^ q[2] ^ q[3] ^ q[5];
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= LFSR_DEFAULT;
    else if (load) q <= (seed == '0) ? LFSR_DEFAULT : seed;
    else if (step) q <= {fb, q[15:1]};
endmodule

// File: rtl/colour_sequencer.sv
// colour_sequencer: Simon colour memory, LED flash timer and move checker
// SIMON_FAST_SIM_EN shortens the flash phases to 8/4 cycles at speed 0.
module colour_sequencer
  import simon_pkg::*;
#(
  parameter int BASE_TICKS = 12_500_000,
  parameter int GAP_TICKS  = 6_250_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rst_seedgen,
  input  logic       start,
  input  logic       load_colour,
  input  logic       load_speed,
  input  logic       flash_clk,
  input  logic [2:0] speed,
  input  logic [5:0] current_round,
  input  logic [5:0] check_round,
  input  logic [3:0] player_input,
  output logic       pulse,
  output logic       result,
  output logic [3:0] led
);
`ifdef SIMON_FAST_SIM_EN
  localparam int ON_BASE  = 8;
  localparam int GAP_BASE = 4;
`else
  localparam int ON_BASE  = BASE_TICKS;
  localparam int GAP_BASE = GAP_TICKS;
`endif
  function automatic logic [31:0] ticks(int base, logic [2:0] s);
    logic [31:0] t;
    t = 32'(base) >> s;
    return (t == '0) ? 32'd1 : t;
  endfunction
  logic [15:0]  seed_q, lfsr_q;
  logic [2:0]   spd_q, fspd_q;
  logic [31:0]  timer_q;
  logic [3:0]   led_q;
  logic         pulse_q, result_q;
  flash_state_t state_q;
  colour_t      mem_q [ROUND_MAX];
  logic [5:0]   diff;
  colour_t      exp_c;
  logic         unused_bits;
  assign diff        = current_round - check_round;
  assign exp_c       = mem_q[diff[4:0]];
  assign unused_bits = ^{diff[5], lfsr_q[15:2]};
  lfsr16 u_lfsr (
    .clk  (clk),
    .reset(reset),
    .load (start),
    .seed (seed_q),
    .step (load_colour),
    .q    (lfsr_q)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      seed_q   <= '0;
      spd_q    <= '0;
      result_q <= 1'b0;
    end else begin
      seed_q   <= rst_seedgen ? '0 : seed_q + 16'd1;
      spd_q    <= load_speed ? speed : spd_q;
      result_q <= player_input == onehot(exp_c);
    end
  always_ff @(posedge clk)
    if (load_colour) mem_q[current_round[4:0] - 5'd1] <= colour_t'(lfsr_q[1:0]);
  // Speed is captured at flash start so a mid-flash load_speed cannot stretch or cut it.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      fspd_q  <= '0;
      led_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: if (flash_clk) begin
          state_q <= ON;
          led_q   <= onehot(exp_c);
          fspd_q  <= spd_q;
          timer_q <= ticks(ON_BASE, spd_q) - 32'd1;
        end
        ON: if (timer_q == '0) begin
          state_q <= GAP;
          led_q   <= '0;
          timer_q <= ticks(GAP_BASE, fspd_q) - 32'd1;
        end else timer_q <= timer_q - 32'd1;
        GAP: if (timer_q == '0) begin
          state_q <= DONE;
          pulse_q <= 1'b1;
        end else timer_q <= timer_q - 32'd1;
        default: state_q <= IDLE;
      endcase
    end
  assign pulse  = pulse_q;
  assign result = result_q;
  assign led    = led_q;
endmodule

// File: doc/colour_sequencer.md
COLOUR_SEQUENCER -- requirements
Module: colour_sequencer

Interface
REQ-001 SHALL have parameter BASE_TICKS, default 12_500_000: on-phase length in clk cycles at speed 0.
REQ-002 SHALL have parameter GAP_TICKS, default 6_250_000: off-phase length in clk cycles at speed 0.
REQ-003 SHALL have one clock and one reset. Ports are listed below as: name, direction, width, meaning.
- clk, input, 1: the single clock.
- reset, input, 1: asynchronous, active-low.
REQ-004 SHALL have the following control inputs from the game controller:
- rst_seedgen, input, 1: clear the seed counter.
- start, input, 1: load the LFSR from the seed.
- load_colour, input, 1: append a colour to the sequence.
- load_speed, input, 1: latch speed.
- flash_clk, input, 1: single-cycle request to start a flash.
REQ-005 SHALL have the following data inputs:
- speed, input, 3: speed level, 0 to 7.
- current_round, input, 6: rounds played, 1 to 32.
- check_round, input, 6: remaining-items count.
- player_input, input, 4: player buttons, one bit per colour.
REQ-006 SHALL have the following outputs:
- pulse, output, 1: single-cycle flash-complete strobe.
- result, output, 1: the player's move matches the expected colour.
- led, output, 4: one-hot colour display.

Function
REQ-007 SHALL run a 16-bit seed counter that increments every cycle and clears to 0 in the cycle after rst_seedgen.
- On start, the seed is copied into the LFSR.
- If the seed is zero, the LFSR loads 16'hACE1 instead.
REQ-008 The LFSR SHALL be a 16-bit Fibonacci LFSR with taps 16,14,13,11. It advances exactly once per load_colour and holds otherwise.
REQ-009 On load_colour, SHALL write lfsr[1:0] (the pre-advance value) to mem[current_round[4:0]-1].
- The subtraction is 5-bit wrapping, so round 32 writes index 31.
- The memory holds 32 entries of 2 bits each.
REQ-010 SHALL define the active index as idx = (current_round - check_round) in 6-bit arithmetic, using bits [4:0].
- The expected colour is mem[idx].
REQ-011 On load_speed, SHALL latch the speed input into spd_q (3 bits). spd_q resets to 0.
REQ-012 The flash timer SHALL be an FSM with states IDLE, ON, GAP and DONE.
- IDLE -> ON on flash_clk. The expected colour is latched into led as a one-hot value: colour 0 = led[0], colour 3 = led[3].
- ON lasts (BASE_TICKS >> spd_q) cycles, then goes to GAP with led = 0.
- GAP lasts (GAP_TICKS >> spd_q) cycles, then goes to DONE.
- DONE asserts pulse for exactly 1 cycle, then returns to IDLE.
REQ-013 flash_clk received outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-014 A shifted tick count of 0 SHALL be treated as 1 cycle.
REQ-015 result SHALL be registered each cycle as (player_input == onehot(mem[idx])).
- Zero bits set, or more than one bit set, gives result = 0.
- result is valid one cycle after player_input settles.
REQ-016 If load_colour and flash_clk arrive in the same cycle, both SHALL be serviced. The flash uses the memory contents from before the write.
REQ-017 load_speed changes SHALL take effect on the next flash only, never on a flash already in progress.

Reset
REQ-018 On reset low, SHALL asynchronously clear all of the following: seed counter, spd_q, timer, led, pulse and result.
- The LFSR resets to 16'hACE1.
- The flash FSM resets to IDLE.
- Memory contents are not reset.
REQ-019 Reset asserted mid-flash SHALL blank led immediately and SHALL NOT emit pulse.

Configuration
REQ-020 SHALL support the macro SIMON_FAST_SIM_EN.
- When defined, the on-phase is 8 >> spd_q cycles and the gap is 4 >> spd_q cycles; the REQ-014 minimum of 1 cycle still applies.
- When undefined, BASE_TICKS and GAP_TICKS are used.
- All other behaviour is identical in both cases.

Structure
REQ-021 The shared package simon_pkg SHALL hold all of the following:
- colour_t enum: RED = 0, GREEN = 1, BLUE = 2, YELLOW = 3.
- ROUND_MAX = 32.
- LFSR_DEFAULT = 16'hACE1.
- flash_state_t.
REQ-022 The LFSR SHALL be the sub-module lfsr16, with ports clk, reset, load, seed, step and q.

Verification
REQ-023 SHALL cover the following directed scenarios, with SIMON_FAST_SIM_EN defined:
- Seed handling: rst_seedgen, wait 0 cycles, start -> LFSR = 16'hACE1. rst_seedgen, wait 9 cycles, start -> LFSR = seed counter value 9.
- Memory write and readback: 3 load_colour pulses with current_round = 1, 2, 3 -> mem[0..2] equal the three successive lfsr[1:0] values. Readback with check_round = 3, 2, 1 returns them in order.
- Flash timing: flash_clk at spd_q = 0 -> led one-hot for 8 cycles, dark for 4 cycles, then pulse high for 1 cycle. At spd_q = 3 -> ON 1 cycle, GAP 1 cycle, pulse.
- Compare: mem[idx] = BLUE, player_input = 4'b0100 -> result = 1 next cycle. player_input = 4'b0110 -> result = 0. player_input = 4'b0000 -> result = 0.
- Reset mid-flash: reset low during ON -> led = 0 and no pulse. After reset high, a new flash_clk completes normally.
- Boundary: current_round = 32 with load_colour -> mem[31] is written. flash_clk during GAP is ignored, so exactly one pulse occurs.
